y86_fetch_unit: RTL and testbench

Parametrised, self-sequencing Y86-64 fetch stage: owns the PC register and a byte-addressed instruction memory, and splits each instruction into icode/ifun/rA/rB/valC/valP. Fetched instructions are emitted on a valid/ready output toward decode. A redirect port serves branch-mispredict and `ret` recovery. Status (AOK/HLT/ADR/INS) is tracked in a small run/halt/error state machine. Successor to the combinational, externally-PC-driven fetch block.

---
 rtl/y86_fetch_unit.sv | 203 ++++++++++++++++++++
 tb/tb_y86_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit -- self-sequencing Y86-64 fetch stage.
//
// Owns the PC register and a byte-addressed instruction memory. Each issued
// fetch decodes the instruction at PC into icode/ifun/rA/rB/valC/valP and
// presents it on a valid/ready output toward decode. A redirect port reloads
// the PC (branch mispredict / ret recovery) and drops any pending output.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_we/waddr/wdata byte write port into instruction memory (any state)
//   redirect_valid/pc   load new PC, flush output, return to RUN
//   out_ready           downstream accepts the current output
//   out_valid, pc_out, icode, ifun, rA, rB, valC, valP, stat
//                       registered fetch result (stat: 0 AOK,1 HLT,2 ADR,3 INS)
//   pred_pc             PC the unit will fetch from next (the PC register)
//
// Build option: define FETCH_PREDICT_TAKEN_EN to follow jXX/call targets
// (static always-taken prediction); otherwise fetch always falls through.
module y86_fetch_unit #(
  parameter int              PC_W      = 64,
  parameter int              MEM_BYTES = 1024,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_BYTES)-1:0] imem_waddr,
  input  logic [7:0]                   imem_wdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [PC_W-1:0]              pc_out,
  output logic [3:0]                   icode,
  output logic [3:0]                   ifun,
  output logic [3:0]                   rA,
  output logic [3:0]                   rB,
  output logic [PC_W-1:0]              valC,
  output logic [PC_W-1:0]              valP,
  output logic [PC_W-1:0]              pred_pc,
  output logic [1:0]                   stat
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [PC_W:0] MEM_END = (PC_W+1)'(MEM_BYTES);
  localparam logic [1:0] STAT_AOK = 2'd0, STAT_HLT = 2'd1,
                         STAT_ADR = 2'd2, STAT_INS = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_ERROR} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q, pc_out_q, valC_q, valP_q;
  logic            out_valid_q;
  logic [3:0]      icode_q, ifun_q, rA_q, rB_q;
  logic [1:0]      stat_q;

  // Instruction memory: not reset, writable in every state.
  logic [7:0] mem_q [MEM_BYTES];
  always_ff @(posedge clk) begin
    if (imem_we) mem_q[imem_waddr] <= imem_wdata;
  end

  // Ten-byte window starting at PC; bytes past the end of memory read 0
  // (such fetches are reported as ADR and their fields are discarded).
  logic [7:0] win [10];
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_win
      logic [PC_W:0] addr;
      assign addr    = {1'b0, pc_q} + (PC_W+1)'(gi);
      assign win[gi] = (addr < MEM_END) ? mem_q[addr[AW-1:0]] : 8'h00;
    end
  endgenerate

  // Decode of the instruction at pc_q.
  logic [3:0]      icode_raw, ifun_raw, len;
  logic            has_reg, ifun_ok, bad_icode, adr;
  logic [63:0]     valc64;
  logic [PC_W:0]   sum;
  logic [3:0]      icode_d, ifun_d, rA_d, rB_d;
  logic [PC_W-1:0] valC_d, next_pc_d;
  logic [1:0]      stat_d;

  always_comb begin
    icode_raw = win[0][7:4];
    ifun_raw  = win[0][3:0];
    len       = 4'd1;
    has_reg   = 1'b0;
    ifun_ok   = (ifun_raw == 4'h0);
    bad_icode = 1'b0;
    valc64    = '0;
    case (icode_raw)
      4'h0, 4'h1, 4'h9: len = 4'd1;
      4'h2: begin len = 4'd2; has_reg = 1'b1; ifun_ok = (ifun_raw <= 4'd6); end
      4'h6: begin len = 4'd2; has_reg = 1'b1; ifun_ok = (ifun_raw <= 4'd3); end
      4'hA, 4'hB: begin len = 4'd2; has_reg = 1'b1; end
      4'h7: begin
        len = 4'd9; ifun_ok = (ifun_raw <= 4'd6);
        valc64 = {win[8], win[7], win[6], win[5], win[4], win[3], win[2], win[1]};
      end
      4'h8: begin
        len = 4'd9;
        valc64 = {win[8], win[7], win[6], win[5], win[4], win[3], win[2], win[1]};
      end
      4'h3, 4'h4, 4'h5: begin
        len = 4'd10; has_reg = 1'b1;
        valc64 = {win[9], win[8], win[7], win[6], win[5], win[4], win[3], win[2]};
      end
      default: bad_icode = 1'b1;
    endcase

    // One extra bit catches PC+len wrapping past PC_W; any byte beyond
    // memory is equivalent to PC+len exceeding MEM_BYTES.
    sum = {1'b0, pc_q} + (PC_W+1)'(len);
    adr = (sum > MEM_END);

    icode_d = icode_raw;
    ifun_d  = ifun_raw;
    rA_d    = has_reg ? win[1][7:4] : 4'hF;
    rB_d    = has_reg ? win[1][3:0] : 4'hF;
    valC_d  = valc64[PC_W-1:0];
    if (adr) begin
      stat_d  = STAT_ADR;
      icode_d = 4'h0;
      ifun_d  = 4'h0;
      rA_d    = 4'hF;
      rB_d    = 4'hF;
      valC_d  = '0;
    end else if (bad_icode || !ifun_ok) begin
      stat_d = STAT_INS;
    end else if (icode_raw == 4'h0) begin
      stat_d = STAT_HLT;
    end else begin
      stat_d = STAT_AOK;
    end

`ifdef FETCH_PREDICT_TAKEN_EN
    next_pc_d = (icode_raw == 4'h7 || icode_raw == 4'h8) ? valC_d : sum[PC_W-1:0];
`else
    next_pc_d = sum[PC_W-1:0];
`endif
  end

  // Run/halt/error sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      pc_out_q    <= '0;
      icode_q     <= 4'h0;
      ifun_q      <= 4'h0;
      rA_q        <= 4'hF;
      rB_q        <= 4'hF;
      valC_q      <= '0;
      valP_q      <= '0;
      stat_q      <= STAT_AOK;
    end else if (redirect_valid) begin
      // Pending output is discarded; the machine restarts cleanly.
      state_q     <= S_RUN;
      pc_q        <= redirect_pc;
      out_valid_q <= 1'b0;
      stat_q      <= STAT_AOK;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b1;
            pc_out_q    <= pc_q;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            rA_q        <= rA_d;
            rB_q        <= rB_d;
            valC_q      <= valC_d;
            valP_q      <= sum[PC_W-1:0];
            stat_q      <= stat_d;
            // PC only advances past good instructions; stopping leaves it
            // on the instruction that stopped the machine.
            case (stat_d)
              STAT_AOK: pc_q    <= next_pc_d;
              STAT_HLT: state_q <= S_HALTED;
              default:  state_q <= S_ERROR;
            endcase
          end
        end
        default: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_out_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = rA_q;
  assign rB        = rB_q;
  assign valC      = valC_q;
  assign valP      = valP_q;
  assign pred_pc   = pc_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [7:0]  imem_wdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] pc_out, valC, valP, pred_pc;
  logic [3:0]  icode, ifun, rA, rB;
  logic [1:0]  stat;

  int checks = 0;
  int errors = 0;

  logic [7:0] tb_mem [1024];

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, next;
    logic [1:0]  stat;
  } fetch_t;

  y86_fetch_unit #(.PC_W(64), .MEM_BYTES(1024), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .pc_out(pc_out),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pred_pc(pred_pc), .stat(stat)
  );

  always #5 clk = ~clk;

  // Instruction-set level reference: what fetching at pc should report.
  function automatic logic [7:0] mb(input longint unsigned a);
    return (a < 1024) ? tb_mem[a] : 8'h00;
  endfunction

  function automatic fetch_t model(input longint unsigned pc);
    fetch_t f;
    logic [7:0] b0;
    int len;
    bit regs, legal;
    b0 = mb(pc);
    f.icode = b0[7:4];
    f.ifun  = b0[3:0];
    case (f.icode)
      4'h0, 4'h1, 4'h9: len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8: len = 9;
      4'h3, 4'h4, 4'h5: len = 10;
      default: len = 1;
    endcase
    regs  = (len == 2) || (len == 10);
    legal = (f.icode == 2 || f.icode == 7) ? (f.ifun <= 6) :
            (f.icode == 6) ? (f.ifun <= 3) :
            (f.icode <= 4'hB) ? (f.ifun == 0) : 1'b0;
    f.ra   = regs ? mb(pc + 1) >> 4 : 4'hF;
    f.rb   = regs ? mb(pc + 1) & 8'h0F : 4'hF;
    f.valc = 0;
    if (len >= 9)
      for (int k = 0; k < 8; k++)
        f.valc = f.valc | (64'(mb(pc + (len == 10 ? 2 : 1) + k)) << (8 * k));
    f.valp = pc + len;
    f.next = f.valp;
`ifdef FETCH_PREDICT_TAKEN_EN
    if (len == 9) f.next = f.valc;
`endif
    if (pc + len > 1024) begin
      f.stat = 2; f.icode = 0; f.ifun = 0; f.ra = 4'hF; f.rb = 4'hF; f.valc = 0;
    end else if (!legal) f.stat = 3;
    else if (f.icode == 0) f.stat = 1;
    else f.stat = 0;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = 10'(a); imem_wdata = d; tb_mem[a] = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic redir(input logic [63:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    chk("redirect_flush", {63'd0, out_valid}, 64'd1 - 64'd1);
  endtask

  task automatic chk_model(input string tag, input logic [63:0] pc);
    fetch_t f;
    f = model(pc);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_icode"}, {60'd0, icode}, {60'd0, f.icode});
    chk({tag, "_ifun"}, {60'd0, ifun}, {60'd0, f.ifun});
    chk({tag, "_stat"}, {62'd0, stat}, {62'd0, f.stat});
    if (f.stat != 3) begin
      chk({tag, "_rA"}, {60'd0, rA}, {60'd0, f.ra});
      chk({tag, "_rB"}, {60'd0, rB}, {60'd0, f.rb});
      chk({tag, "_valC"}, valC, f.valc);
      chk({tag, "_valP"}, valP, f.valp);
    end
  endtask

  task automatic fields(input string tag, input logic [63:0] pc, input logic [3:0] ic,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] c, input logic [63:0] p, input logic [1:0] st);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_icode"}, {60'd0, icode}, {60'd0, ic});
    chk({tag, "_rA"}, {60'd0, rA}, {60'd0, a});
    chk({tag, "_rB"}, {60'd0, rB}, {60'd0, b});
    chk({tag, "_valC"}, valC, c);
    chk({tag, "_valP"}, valP, p);
    chk({tag, "_stat"}, {62'd0, stat}, {62'd0, st});
  endtask

  task automatic idle_chk(input string tag, input int n, input logic [63:0] pc);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_pc"}, pc_out, pc);
    end
  endtask

  initial begin
    fetch_t f;
    logic [63:0] mpc, exp_next;
    int a, cyc, n_in;
    bit done, redirected, rdy, rd;
    logic [3:0] ic, fn;
    logic [7:0] prog0 [12];

    // Hold reset while loading: random background, then the test program.
    for (int k = 0; k < 1024; k++) wr(k, 8'($urandom));
    prog0 = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h10, 8'h00};
    for (int k = 0; k < 12; k++) wr(k, prog0[k]);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stat", {62'd0, stat}, 64'd0);
    chk("rst_rArB", {56'd0, rA, rB}, 64'hFF);
    chk("rst_pred_pc", pred_pc, 64'h0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_valP", valP, 64'h0);
    chk("rst_icode", {60'd0, icode}, 64'd0);

    // irmovq held by backpressure for three cycles, then nop, then halt.
    rst_n = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      fields("irmovq_stall", 64'h0, 4'h3, 4'hF, 4'h2, 64'd10, 64'd10, 2'd0);
      chk("stall_pred_pc", pred_pc, 64'd10);
    end
    out_ready = 1'b1;
    tick(); fields("nop", 64'd10, 4'h1, 4'hF, 4'hF, 64'd0, 64'd11, 2'd0);
    tick(); fields("halt", 64'd11, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 2'd1);
    idle_chk("halted", 7, 64'd11);

    // Redirect out of HALTED.
    wr(256, 8'h10); wr(257, 8'h00);
    redir(64'h100);
    tick(); fields("redir_nop", 64'h100, 4'h1, 4'hF, 4'hF, 64'd0, 64'h101, 2'd0);
    tick(); chk_model("redir_halt", 64'h101);
    idle_chk("redir_halted", 1, 64'h101);

    // jXX at 0x20 targeting 0x40.
    wr(32, 8'h70); wr(33, 8'h40);
    for (int k = 34; k < 41; k++) wr(k, 8'h00);
    wr(41, 8'h00); wr(64, 8'h00);
`ifdef FETCH_PREDICT_TAKEN_EN
    exp_next = 64'h40;
`else
    exp_next = 64'h29;
`endif
    redir(64'h20);
    tick(); fields("jxx", 64'h20, 4'h7, 4'hF, 4'hF, 64'h40, 64'h29, 2'd0);
    chk("jxx_pred_pc", pred_pc, exp_next);
    tick(); chk("jxx_next_pc", pc_out, exp_next);
    chk("jxx_next_stat", {62'd0, stat}, 64'd1);
    idle_chk("jxx_halted", 1, exp_next);

    // Error cases.
    wr(80, 8'hC0);
    redir(64'h50);
    tick(); chk("ins_stat", {62'd0, stat}, 64'd3); chk("ins_pc", pc_out, 64'h50);
    chk("ins_icode", {60'd0, icode}, 64'hC);
    idle_chk("ins_stop", 3, 64'h50);
    wr(1020, 8'h30);
    redir(64'd1020);
    tick(); fields("adr", 64'd1020, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1030, 2'd2);
    chk("adr_ifun", {60'd0, ifun}, 64'd0);
    idle_chk("adr_stop", 3, 64'd1020);
    wr(96, 8'h25); wr(97, 8'h12); wr(98, 8'h63); wr(99, 8'h45); wr(100, 8'h64); wr(101, 8'h00);
    redir(64'h60);
    tick(); fields("rrmov5", 64'h60, 4'h2, 4'h1, 4'h2, 64'd0, 64'h62, 2'd0);
    chk("rrmov5_ifun", {60'd0, ifun}, 64'd5);
    tick(); fields("op3", 64'h62, 4'h6, 4'h4, 4'h5, 64'd0, 64'h64, 2'd0);
    tick(); chk("op4_stat", {62'd0, stat}, 64'd3); chk("op4_pc", pc_out, 64'h64);
    idle_chk("op4_stop", 2, 64'h64);

    // Random instruction streams with random backpressure and one restart.
    for (int r = 0; r < 6; r++) begin
      a = 512;
      n_in = $urandom_range(5, 20);
      for (int k = 0; k < n_in; k++) begin
        ic = 4'($urandom_range(1, 11));
        fn = (ic == 2 || ic == 7) ? 4'($urandom_range(0, 6)) :
             (ic == 6) ? 4'($urandom_range(0, 3)) : 4'h0;
        wr(a, {ic, fn}); a++;
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
          wr(a, 8'($urandom)); a++;
        end
        if (ic inside {4'h3, 4'h4, 4'h5})
          for (int k2 = 0; k2 < 8; k2++) begin wr(a, 8'($urandom)); a++; end
        if (ic == 4'h7 || ic == 4'h8) begin
          mpc = 64'(a + 8);   // target = following instruction
          for (int k2 = 0; k2 < 8; k2++) begin wr(a, mpc[8*k2 +: 8]); a++; end
        end
      end
      if ($urandom_range(0, 3) == 0) wr(a, 8'hC0 | 8'($urandom_range(0, 15)));
      else wr(a, 8'h00);

      redir(64'd512);
      mpc = 64'd512; done = 0; redirected = 0; cyc = 0;
      while (!done && cyc < 600) begin
        rdy = ($urandom_range(0, 3) != 0);
        rd  = (!redirected && cyc > 5 && $urandom_range(0, 15) == 0);
        out_ready = rdy; redirect_valid = rd; redirect_pc = 64'd512;
        if (rd) begin
          redirected = 1; mpc = 64'd512;
        end else if (out_valid && rdy) begin
          f = model(mpc);
          chk_model("rnd", mpc);
          $display("txn round=%0d pc=%0h icode=%0h ifun=%0h stat=%0d", r, pc_out, icode, ifun, stat);
          if (f.stat != 0) done = 1;
          else mpc = f.next;
        end
        tick(); cyc++;
      end
      redirect_valid = 1'b0; out_ready = 1'b1;
      chk("rnd_round_done", {63'd0, done}, 64'd1);
      idle_chk("rnd_stop", 2, mpc);
    end

    // Mid-stream reset: overrides a simultaneous redirect, while a memory
    // write in the same cycle still lands.
    redir(64'd512);
    tick(); tick();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h300;
    wr(2, 8'h0B);
    rst_n = 1'b1; redirect_valid = 1'b0;
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_stat", {62'd0, stat}, 64'd0);
    chk("mrst_pred_pc", pred_pc, 64'h0);
    tick(); fields("mrst_irmovq", 64'h0, 4'h3, 4'hF, 4'h2, 64'd11, 64'd10, 2'd0);
    tick(); fields("mrst_nop", 64'd10, 4'h1, 4'hF, 4'hF, 64'd0, 64'd11, 2'd0);
    tick(); chk("mrst_halt", {62'd0, stat}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
